// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: response codes and the write-arbiter state encoding.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    ADDR_DATA,
    RESP
  } wr_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority picker: first requester found scanning from last_grant+1
// with wrap. Shared by the write and read arbiters.
module rr_arbiter #(
  parameter int  NUM_M = 2,
  localparam int IW    = $clog2(NUM_M)
) (
  input  logic [NUM_M-1:0] req,
  input  logic [IW-1:0]    last_grant,
  output logic [IW-1:0]    grant,
  output logic             any_req
);

  int idx;

  // Scan from the farthest offset down so the nearest requester after last_grant wins.
  always_comb begin
    grant   = '0;
    any_req = |req;
    idx     = 0;
    for (int k = NUM_M; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % NUM_M;
      if (req[idx]) grant = IW'(idx);
    end
  end

endmodule

// File: rtl/axi_lite_wr_arbiter.sv
// N-master to 1-slave AXI-Lite write arbiter: round-robin grant, one outstanding write,
// B response routed back to the issuing master.
module axi_lite_wr_arbiter
  import axi_lite_pkg::*;
#(
  parameter int NUM_M      = 2,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_M*ADDR_WIDTH-1:0]   M_AW_ADDR,
  input  logic [NUM_M-1:0]              M_AW_VALID,
  output logic [NUM_M-1:0]              M_AW_READY,
  input  logic [NUM_M*DATA_WIDTH-1:0]   M_W_DATA,
  input  logic [NUM_M*DATA_WIDTH/8-1:0] M_W_STRB,
  input  logic [NUM_M-1:0]              M_W_VALID,
  output logic [NUM_M-1:0]              M_W_READY,
  output logic [NUM_M*2-1:0]            M_B_RESP,
  output logic [NUM_M-1:0]              M_B_VALID,
  input  logic [NUM_M-1:0]              M_B_READY,
  output logic [ADDR_WIDTH-1:0]         S_AW_ADDR,
  output logic                          S_AW_VALID,
  input  logic                          S_AW_READY,
  output logic [DATA_WIDTH-1:0]         S_W_DATA,
  output logic [DATA_WIDTH/8-1:0]       S_W_STRB,
  output logic                          S_W_VALID,
  input  logic                          S_W_READY,
  input  logic [1:0]                    S_B_RESP,
  input  logic                          S_B_VALID,
  output logic                          S_B_READY
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int IW = $clog2(NUM_M);

  logic [NUM_M-1:0][ADDR_WIDTH-1:0] aw_addr;
  logic [NUM_M-1:0][DATA_WIDTH-1:0] w_data;
  logic [NUM_M-1:0][SW-1:0]         w_strb;
  logic [NUM_M-1:0][1:0]            b_resp;

  assign aw_addr  = M_AW_ADDR;
  assign w_data   = M_W_DATA;
  assign w_strb   = M_W_STRB;
  assign M_B_RESP = b_resp;

  wr_arb_state_t state, state_nxt;
  logic [IW-1:0] grant, grant_nxt, last_grant, last_nxt, pick;
  logic          aw_done, aw_done_nxt, w_done, w_done_nxt;
  logic          any_req, aw_hs, w_hs;

  rr_arbiter #(.NUM_M(NUM_M)) u_rr (
    .req        (M_AW_VALID),
    .last_grant (last_grant),
    .grant      (pick),
    .any_req    (any_req)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= IW'(NUM_M - 1);
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_nxt;
      aw_done    <= aw_done_nxt;
      w_done     <= w_done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    last_nxt    = last_grant;
    aw_done_nxt = aw_done;
    w_done_nxt  = w_done;
    aw_hs       = 1'b0;
    w_hs        = 1'b0;
    S_AW_ADDR   = '0;
    S_AW_VALID  = 1'b0;
    S_W_DATA    = '0;
    S_W_STRB    = '0;
    S_W_VALID   = 1'b0;
    S_B_READY   = 1'b0;
    M_AW_READY  = '0;
    M_W_READY   = '0;
    M_B_VALID   = '0;
    b_resp      = '0;
    case (state)
      IDLE: begin
        if (any_req) begin
          grant_nxt = pick;
          state_nxt = ADDR_DATA;
        end
      end
      ADDR_DATA: begin
        S_AW_ADDR         = aw_addr[grant];
        S_AW_VALID        = M_AW_VALID[grant] & ~aw_done;
        M_AW_READY[grant] = S_AW_READY & ~aw_done;
        S_W_DATA          = w_data[grant];
        S_W_STRB          = w_strb[grant];
        S_W_VALID         = M_W_VALID[grant] & ~w_done;
        M_W_READY[grant]  = S_W_READY & ~w_done;
        aw_hs             = S_AW_VALID & S_AW_READY;
        w_hs              = S_W_VALID & S_W_READY;
        // AW and W may complete in either order or together; flags only track the earlier one.
        if ((aw_done | aw_hs) && (w_done | w_hs)) begin
          state_nxt   = RESP;
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
        end else begin
          aw_done_nxt = aw_done | aw_hs;
          w_done_nxt  = w_done | w_hs;
        end
      end
      RESP: begin
        M_B_VALID[grant] = S_B_VALID;
        b_resp[grant]    = S_B_RESP;
        S_B_READY        = M_B_READY[grant];
        if (S_B_VALID && M_B_READY[grant]) begin
          last_nxt  = grant;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_lite_wr_arbiter.sv
// Bench for axi_lite_wr_arbiter: transaction-level owner/phase model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_axi_lite_wr_arbiter;

  localparam int N  = 2;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N*AW-1:0] m_aw_addr = '0;
  logic [N-1:0]    m_aw_valid = '0, m_aw_ready;
  logic [N*DW-1:0] m_w_data = '0;
  logic [N*SW-1:0] m_w_strb = '0;
  logic [N-1:0]    m_w_valid = '0, m_w_ready;
  logic [N*2-1:0]  m_b_resp;
  logic [N-1:0]    m_b_valid, m_b_ready = '0;
  logic [AW-1:0]   s_aw_addr;
  logic            s_aw_valid, s_aw_ready = 1'b0;
  logic [DW-1:0]   s_w_data;
  logic [SW-1:0]   s_w_strb;
  logic            s_w_valid, s_w_ready = 1'b0;
  logic [1:0]      s_b_resp = '0;
  logic            s_b_valid = 1'b0, s_b_ready;

  axi_lite_wr_arbiter #(.NUM_M(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .M_AW_ADDR(m_aw_addr), .M_AW_VALID(m_aw_valid), .M_AW_READY(m_aw_ready),
    .M_W_DATA(m_w_data), .M_W_STRB(m_w_strb), .M_W_VALID(m_w_valid), .M_W_READY(m_w_ready),
    .M_B_RESP(m_b_resp), .M_B_VALID(m_b_valid), .M_B_READY(m_b_ready),
    .S_AW_ADDR(s_aw_addr), .S_AW_VALID(s_aw_valid), .S_AW_READY(s_aw_ready),
    .S_W_DATA(s_w_data), .S_W_STRB(s_w_strb), .S_W_VALID(s_w_valid), .S_W_READY(s_w_ready),
    .S_B_RESP(s_b_resp), .S_B_VALID(s_b_valid), .S_B_READY(s_b_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the slave (-1 = nobody), which halves of the write are done, and
  // whether the write is waiting on its response.
  int  own = -1, n_own = -1, last = N - 1, n_last = N - 1;
  bit  aw_ok, w_ok, in_resp, n_aw, n_w, n_resp;
  logic [AW-1:0] aw_log[$];
  int            b_own_log[$];
  logic [1:0]    b_resp_log[$];
  bit            auto_clr = 1'b1;
  logic [N-1:0]  clr_aw, clr_w;

  task automatic check_and_step();
    logic          e_saw_v, e_sw_v, e_sb_r, awh, wh;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic [SW-1:0] e_strb;
    logic [N-1:0]  e_awr, e_wr, e_bv;
    logic [2*N-1:0] e_br;
    e_saw_v = 0; e_sw_v = 0; e_sb_r = 0; e_addr = '0; e_data = '0; e_strb = '0;
    e_awr = '0; e_wr = '0; e_bv = '0; e_br = '0;
    n_own = own; n_last = last; n_aw = aw_ok; n_w = w_ok; n_resp = in_resp;
    if (!rst) begin
      n_own = -1; n_last = N - 1; n_aw = 0; n_w = 0; n_resp = 0;
    end else if (own < 0) begin
      for (int k = 1; k <= N; k++)
        if (n_own < 0 && m_aw_valid[(last + k) % N]) n_own = (last + k) % N;
    end else if (!in_resp) begin
      e_addr     = m_aw_addr[own*AW +: AW];
      e_data     = m_w_data[own*DW +: DW];
      e_strb     = m_w_strb[own*SW +: SW];
      e_saw_v    = m_aw_valid[own] & !aw_ok;
      e_sw_v     = m_w_valid[own] & !w_ok;
      e_awr[own] = s_aw_ready & !aw_ok;
      e_wr[own]  = s_w_ready & !w_ok;
      awh = e_saw_v & s_aw_ready;
      wh  = e_sw_v & s_w_ready;
      if (awh) aw_log.push_back(e_addr);
      if ((aw_ok | awh) && (w_ok | wh)) begin
        n_resp = 1; n_aw = 0; n_w = 0;
      end else begin
        n_aw = aw_ok | awh; n_w = w_ok | wh;
      end
    end else begin
      e_bv[own]        = s_b_valid;
      e_br[own*2 +: 2] = s_b_resp;
      e_sb_r           = m_b_ready[own];
      if (s_b_valid && m_b_ready[own]) begin
        b_own_log.push_back(own);
        b_resp_log.push_back(s_b_resp);
        n_last = own; n_own = -1; n_resp = 0;
      end
    end
    chk("s_aw_valid", s_aw_valid, e_saw_v);
    chk("s_aw_addr",  s_aw_addr,  e_addr);
    chk("s_w_valid",  s_w_valid,  e_sw_v);
    chk("s_w_data",   s_w_data,   e_data);
    chk("s_w_strb",   s_w_strb,   e_strb);
    chk("s_b_ready",  s_b_ready,  e_sb_r);
    chk("m_aw_ready", m_aw_ready, e_awr);
    chk("m_w_ready",  m_w_ready,  e_wr);
    chk("m_b_valid",  m_b_valid,  e_bv);
    chk("m_b_resp",   m_b_resp,   e_br);
    clr_aw = m_aw_valid & m_aw_ready & {N{auto_clr}};
    clr_w  = m_w_valid & m_w_ready & {N{auto_clr}};
  endtask

  task automatic cycle();
    @(negedge clk);
    check_and_step();
    @(posedge clk);
    own = n_own; last = n_last; aw_ok = n_aw; w_ok = n_w; in_resp = n_resp;
    #1;
    m_aw_valid &= ~clr_aw;
    m_w_valid  &= ~clr_w;
  endtask

  task automatic run_until(int nb, int budget);
    int c = 0;
    while (b_own_log.size() < nb && c < budget) begin
      cycle();
      c++;
    end
    chk("b_count", b_own_log.size(), nb);
  endtask

  task automatic set_m(int i, logic [AW-1:0] a, logic [DW-1:0] d, logic [SW-1:0] s);
    m_aw_addr[i*AW +: AW] = a;
    m_w_data[i*DW +: DW]  = d;
    m_w_strb[i*SW +: SW]  = s;
    m_aw_valid[i] = 1'b1;
    m_w_valid[i]  = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    m_aw_valid = '0; m_w_valid = '0; m_b_ready = '1;
    s_aw_ready = 1'b1; s_w_ready = 1'b1; s_b_valid = 1'b1; s_b_resp = 2'b00;
    auto_clr = 1'b1;
    cycle();
    cycle();
    rst = 1'b1;
    aw_log.delete(); b_own_log.delete(); b_resp_log.delete();
  endtask

  task automatic split(bit aw_first);
    do_reset();
    auto_clr = 1'b0;
    s_aw_ready = aw_first; s_w_ready = !aw_first;
    set_m(0, 10'h040, 32'h40, 4'hF);
    cycle();
    cycle();
    cycle();
    cycle();
    if (aw_first) chk("split_aw_masked", {s_aw_valid, m_aw_ready}, 0);
    else          chk("split_w_masked",  {s_w_valid, m_w_ready}, 0);
    chk("split_no_b", m_b_valid, 0);
    s_aw_ready = 1'b1; s_w_ready = 1'b1;
    cycle();
    m_aw_valid = '0; m_w_valid = '0;
    chk("split_resp_bvalid", m_b_valid, 2'b01);
    run_until(1, 10);
    chk("split_aw_count", aw_log.size(), 1);
    chk("split_addr", aw_log[0], 10'h040);
  endtask

  initial begin
    // Single master
    do_reset();
    set_m(0, 10'h004, 32'h4, 4'hF);
    cycle();
    chk("t1_s_aw_valid", s_aw_valid, 1);
    chk("t1_s_w_valid", s_w_valid, 1);
    chk("t1_s_aw_addr", s_aw_addr, 10'h004);
    chk("t1_m_aw_ready", m_aw_ready, 2'b01);
    run_until(1, 20);
    chk("t1_b_owner", b_own_log[0], 0);
    chk("t1_b_resp", b_resp_log[0], 2'b00);

    // Simultaneous requests
    do_reset();
    set_m(0, 10'h008, 32'h8, 4'hF);
    set_m(1, 10'h100, 32'h100, 4'hF);
    run_until(2, 30);
    chk("t2_addr0", aw_log[0], 10'h008);
    chk("t2_addr1", aw_log[1], 10'h100);
    chk("t2_b_owner1", b_own_log[1], 1);

    // Round-robin under continuous requests
    do_reset();
    auto_clr = 1'b0;
    set_m(0, 10'h010, 32'h10, 4'hF);
    set_m(1, 10'h020, 32'h20, 4'hF);
    run_until(6, 60);
    for (int i = 0; i < 6; i++) chk($sformatf("t3_rr%0d", i), aw_log[i], (i % 2) ? 10'h020 : 10'h010);

    // Split handshakes
    split(1'b0);
    split(1'b1);

    // B backpressure with SLVERR
    do_reset();
    s_b_resp = 2'b10; m_b_ready = 2'b01;
    set_m(1, 10'h0C0, 32'hC0, 4'h3);
    cycle();
    cycle();
    set_m(0, 10'h0A0, 32'hA0, 4'hF);
    for (int i = 0; i < 3; i++) begin
      chk("t5_m_b_valid", m_b_valid, 2'b10);
      chk("t5_m_b_resp", m_b_resp, 4'b1000);
      chk("t5_s_b_ready", s_b_ready, 0);
      chk("t5_no_grant", s_aw_valid, 0);
      cycle();
    end
    m_b_ready = 2'b11;
    run_until(2, 20);
    chk("t5_b_owner0", b_own_log[0], 1);
    chk("t5_b_resp0", b_resp_log[0], 2'b10);
    chk("t5_next_addr", aw_log[1], 10'h0A0);

    // Reset in the middle of ADDR_DATA
    do_reset();
    s_aw_ready = 1'b0; s_w_ready = 1'b0;
    set_m(1, 10'h0E0, 32'hE0, 4'hF);
    cycle();
    chk("t6_pre_s_aw_valid", s_aw_valid, 1);
    #1 rst = 1'b0;
    #1;
    chk("t6_s_aw_valid", s_aw_valid, 0);
    chk("t6_s_aw_addr", s_aw_addr, 0);
    chk("t6_m_ready", {m_aw_ready, m_w_ready}, 0);
    set_m(0, 10'h0F0, 32'hF0, 4'hF);
    cycle();
    rst = 1'b1;
    s_aw_ready = 1'b1; s_w_ready = 1'b1;
    run_until(2, 30);
    chk("t6_first_after_reset", aw_log[0], 10'h0F0);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) m_aw_addr = (N*AW)'($urandom);
      m_w_data   = {$urandom, $urandom};
      m_w_strb   = (N*SW)'($urandom);
      m_aw_valid |= N'($urandom) & N'($urandom);
      m_w_valid  |= N'($urandom) & N'($urandom);
      m_b_ready  = N'($urandom);
      s_aw_ready = 1'($urandom);
      s_w_ready  = 1'($urandom);
      s_b_valid  = 1'($urandom);
      s_b_resp   = 2'($urandom);
      cycle();
    end
    chk("rand_progress", b_own_log.size() > 100, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
